// File: rtl/branch_unit.sv
// ============================================================================
// Module      : branch_unit
// Description : Flag-driven branch evaluation, target computation and
//               PC-load / link-register write sequencing.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module branch_unit #(
    parameter int PC_W     = 9,
    parameter int REG_SIZE = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [2:0]          status_in,
    input  logic                load_s,
    input  logic                start,
    input  logic [2:0]          op,
    input  logic [7:0]          imm8,
    input  logic [PC_W-1:0]     pc,
    input  logic [REG_SIZE-1:0] rd_val,
    output logic [2:0]          status_q,
    output logic                busy,
    output logic                taken,
    output logic                load_pc,
    output logic [PC_W-1:0]     pc_next,
    output logic                link_we,
    output logic [REG_SIZE-1:0] link_data,
    output logic                done
);

    localparam logic [2:0] OP_B   = 3'b000;
    localparam logic [2:0] OP_BEQ = 3'b001;
    localparam logic [2:0] OP_BNE = 3'b010;
    localparam logic [2:0] OP_BLT = 3'b011;
    localparam logic [2:0] OP_BLE = 3'b100;
    localparam logic [2:0] OP_BL  = 3'b101;
    localparam logic [2:0] OP_BX  = 3'b110;
    localparam logic [2:0] OP_BLX = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_EVAL   = 2'd1,
        S_LINK   = 2'd2,
        S_UPDATE = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [2:0]            status_d;
    logic [2:0]            op_q, op_d;
    logic [7:0]            imm_q, imm_d;
    logic [PC_W-1:0]       pc_q, pc_d;
    logic [PC_W-1:0]       rd_q, rd_d;
    logic                  taken_q, taken_d;
    logic [PC_W-1:0]       pc_next_q, pc_next_d;
    logic [REG_SIZE-1:0]   link_data_q, link_data_d;

    logic                  w_flag_n, w_flag_v, w_flag_z;
    logic                  w_cond;
    logic                  w_is_link;
    logic                  w_is_reg;
    logic [PC_W-1:0]       w_pc_inc;
    logic [PC_W-1:0]       w_imm_ext;
    logic [PC_W-1:0]       w_target;

    // Only the low PC_W bits of the register operand can ever reach the PC.
    generate
        if (REG_SIZE > PC_W) begin : g_rd_upper
            logic unused_rd_upper;
            assign unused_rd_upper = ^rd_val[REG_SIZE-1:PC_W];
        end
    endgenerate

    assign w_flag_n  = status_q[2];
    assign w_flag_v  = status_q[1];
    assign w_flag_z  = status_q[0];
    assign w_is_link = (op_q == OP_BL) || (op_q == OP_BLX);
    assign w_is_reg  = (op_q == OP_BX) || (op_q == OP_BLX);

    // Arithmetic is PC_W wide so relative targets wrap in both directions.
    assign w_pc_inc  = pc_q + PC_W'(1);
    assign w_imm_ext = PC_W'($signed(imm_q));
    assign w_target  = w_is_reg ? rd_q : (w_pc_inc + w_imm_ext);

    always_comb begin
        w_cond = 1'b0;
        case (op_q)
            OP_B, OP_BL, OP_BX, OP_BLX: w_cond = 1'b1;
            OP_BEQ:                     w_cond = w_flag_z;
            OP_BNE:                     w_cond = ~w_flag_z;
            OP_BLT:                     w_cond = w_flag_n ^ w_flag_v;
            OP_BLE:                     w_cond = (w_flag_n ^ w_flag_v) | w_flag_z;
            default:                    w_cond = 1'b0;
        endcase
    end

    assign status_d = load_s ? status_in : status_q;

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        imm_d       = imm_q;
        pc_d        = pc_q;
        rd_d        = rd_q;
        taken_d     = taken_q;
        pc_next_d   = pc_next_q;
        link_data_d = link_data_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_EVAL;
                    op_d    = op;
                    imm_d   = imm8;
                    pc_d    = pc;
                    rd_d    = rd_val[PC_W-1:0];
                    taken_d = 1'b0;
                end
            end
            S_EVAL: begin
                taken_d   = w_cond;
                pc_next_d = w_cond ? w_target : w_pc_inc;
                if (w_is_link) begin
                    state_d     = S_LINK;
                    link_data_d = REG_SIZE'(w_pc_inc);
                end else begin
                    state_d = S_UPDATE;
                end
            end
            S_LINK: begin
                state_d = S_UPDATE;
            end
            S_UPDATE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            status_q    <= 3'b000;
            op_q        <= 3'b000;
            imm_q       <= 8'h00;
            pc_q        <= '0;
            rd_q        <= '0;
            taken_q     <= 1'b0;
            pc_next_q   <= '0;
            link_data_q <= '0;
        end else begin
            state_q     <= state_d;
            status_q    <= status_d;
            op_q        <= op_d;
            imm_q       <= imm_d;
            pc_q        <= pc_d;
            rd_q        <= rd_d;
            taken_q     <= taken_d;
            pc_next_q   <= pc_next_d;
            link_data_q <= link_data_d;
        end
    end

    // Strobes decode straight from the state register, so each lasts one cycle.
    assign busy      = (state_q != S_IDLE);
    assign load_pc   = (state_q == S_UPDATE);
    assign done      = (state_q == S_UPDATE);
    assign link_we   = (state_q == S_LINK);
    assign taken     = taken_q;
    assign pc_next   = pc_next_q;
    assign link_data = link_data_q;

endmodule

`default_nettype wire

// File: tb/tb_branch_unit.sv
// ============================================================================
// Module      : tb_branch_unit
// Description : Scoreboard bench for branch_unit with directed branch vectors.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_branch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  status_in;
    logic        load_s;
    logic        start;
    logic [2:0]  op;
    logic [7:0]  imm8;
    logic [8:0]  pc;
    logic [15:0] rd_val;
    logic [2:0]  status_q;
    logic        busy;
    logic        taken;
    logic        load_pc;
    logic [8:0]  pc_next;
    logic        link_we;
    logic [15:0] link_data;
    logic        done;

    typedef struct {
        bit          is_link;
        int          cyc;
        logic [15:0] val;
        bit          tk;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    branch_unit #(.PC_W(9), .REG_SIZE(16)) dut (
        .clk(clk), .reset(reset), .status_in(status_in), .load_s(load_s),
        .start(start), .op(op), .imm8(imm8), .pc(pc), .rd_val(rd_val),
        .status_q(status_q), .busy(busy), .taken(taken), .load_pc(load_pc),
        .pc_next(pc_next), .link_we(link_we), .link_data(link_data), .done(done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, got, want, cyc);
        end
    endtask

    // Monitor: every strobe must match the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        if (load_pc && link_we) chk("strobe_overlap", 32'd1, 32'd0);
        if (done && !load_pc)   chk("done_without_load_pc", 32'd1, 32'd0);
        if (load_pc || link_we) begin
            if (sb.size() == 0) begin
                chk("unexpected_strobe", {30'd0, link_we, load_pc}, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("strobe_kind", {31'd0, link_we}, {31'd0, e.is_link});
                chk("strobe_cycle", cyc, e.cyc);
                if (e.is_link) begin
                    chk("link_data", {16'd0, link_data}, {16'd0, e.val});
                end else begin
                    chk("pc_next", {23'd0, pc_next}, {16'd0, e.val});
                    chk("taken", {31'd0, taken}, {31'd0, e.tk});
                    chk("done", {31'd0, done}, 32'd1);
                end
            end
        end
    end

    task automatic load_status(input logic [2:0] v);
        @(negedge clk);
        status_in = v;
        load_s    = 1'b1;
        @(negedge clk);
        load_s    = 1'b0;
    endtask

    // mode: 0 plain, 1 load_s during EVAL, 2 extra start during EVAL,
    //       3 reset during LINK, 4 load_s (Z=1) together with start
    task automatic issue(input logic [2:0] o, input logic [7:0] im, input logic [8:0] p,
                         input logic [15:0] rv, input bit exp_tk, input logic [8:0] exp_pc,
                         input logic [15:0] exp_link, input int mode);
        int k;
        bit lnk;
        lnk = (o == 3'd5) || (o == 3'd7);
        @(negedge clk);
        op = o; imm8 = im; pc = p; rd_val = rv; start = 1'b1;
        if (mode == 4) begin
            status_in = 3'b001;
            load_s    = 1'b1;
        end
        @(posedge clk);
        #1;
        k = cyc;
        if (lnk) sb.push_back('{1'b1, k + 1, exp_link, exp_tk});
        if (mode != 3) sb.push_back('{1'b0, lnk ? k + 2 : k + 1, {7'd0, exp_pc}, exp_tk});
        @(negedge clk);
        start  = 1'b0;
        load_s = 1'b0;
        if (mode == 1) begin
            status_in = 3'b000;
            load_s    = 1'b1;
        end
        if (mode == 2) begin
            start = 1'b1; op = 3'd0; pc = 9'd100; imm8 = 8'd7;
        end
        if (mode == 3) begin
            @(negedge clk);
            reset = 1'b1;
        end
        @(negedge clk);
        start  = 1'b0;
        load_s = 1'b0;
        reset  = 1'b0;
        if (mode == 1) chk("status_after_eval_load", {29'd0, status_q}, 32'd0);
        for (int i = 0; i < 10 && busy; i++) @(negedge clk);
        if (busy) chk("busy_timeout", 32'd1, 32'd0);
    endtask

    initial begin
        reset = 1'b1; status_in = 3'b000; load_s = 1'b0; start = 1'b0;
        op = 3'd0; imm8 = 8'd0; pc = 9'd0; rd_val = 16'd0;
        repeat (3) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        chk("busy_in_reset", {31'd0, busy}, 32'd0);
        start = 1'b0;
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("idle_outputs", {status_q, busy, taken, load_pc, pc_next, link_we, link_data, done}, 32'd0);
        end

        load_status(3'b001);
        issue(3'd1, 8'hFE, 9'd10,  16'd0,    1'b1, 9'd9,   16'd0,  0);
        load_status(3'b110);
        issue(3'd3, 8'd5,  9'd20,  16'd0,    1'b0, 9'd21,  16'd0,  0);
        load_status(3'b100);
        issue(3'd3, 8'd5,  9'd20,  16'd0,    1'b1, 9'd26,  16'd0,  0);
        issue(3'd0, 8'h03, 9'd511, 16'd0,    1'b1, 9'd3,   16'd0,  0);
        issue(3'd0, 8'h80, 9'd0,   16'd0,    1'b1, 9'd385, 16'd0,  2);
        issue(3'd7, 8'd0,  9'd40,  16'h0123, 1'b1, 9'h123, 16'd41, 0);
        issue(3'd2, 8'd4,  9'd50,  16'd0,    1'b0, 9'd51,  16'd0,  4);
        issue(3'd1, 8'd2,  9'd60,  16'd0,    1'b1, 9'd63,  16'd0,  1);
        issue(3'd4, 8'hF0, 9'd70,  16'd0,    1'b0, 9'd71,  16'd0,  0);
        issue(3'd5, 8'h0A, 9'd5,   16'd0,    1'b1, 9'd16,  16'd6,  0);
        issue(3'd6, 8'd0,  9'd7,   16'hFFFF, 1'b1, 9'd511, 16'd0,  0);
        issue(3'd5, 8'd1,  9'd30,  16'd0,    1'b1, 9'd32,  16'd31, 3);

        chk("post_reset_state", {status_q, busy, taken, pc_next, link_data}, 32'd0);
        repeat (5) @(negedge clk);
        chk("scoreboard_empty", sb.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
